fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch-queue entries; power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_3000, fetch address loaded on reset.
REQ-003 Parameter IMEM_AW, default 10, instruction-memory word-address width.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port stop  input  1  consumer stall; when 1, the head entry is not consumed.
REQ-007 Port npc_on  input  1  redirect request; when 1, fetch restarts at pc_next.
REQ-008 Port pc_next  input  32  redirect target address.
REQ-009 Port imem_addr  output  IMEM_AW  word address to instruction memory, equal to fpc[IMEM_AW+1:2].
REQ-010 Port imem_data  input  32  instruction word at imem_addr, combinational read in the same cycle.
REQ-011 Port ins  output  32  head instruction; 32'h0 when valid=0.
REQ-012 Port pc_now  output  32  PC of the head instruction; 32'h0 when valid=0.
REQ-013 Port valid  output  1  1 when ins/pc_now hold a real instruction.
REQ-014 Port count  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-015 The internal fetch PC register fpc always holds a word-aligned value with bits [1:0] = 0.
REQ-016 A push of {fpc, imem_data} into the queue tail occurs when npc_on=0 and (count<DEPTH or a pop occurs in the same cycle); fpc then advances by 4.
REQ-017 A pop of the head entry occurs when valid=1, stop=0 and npc_on=0.
REQ-018 Push and pop in the same cycle leave count unchanged; a full queue with a pop accepts the push.
REQ-019 A push becomes visible at the head no earlier than the next cycle, giving 1-cycle fetch-to-output latency when empty.
REQ-020 When npc_on=1, regardless of stop, all entries are discarded, count becomes 0, fpc loads {pc_next[31:2],2'b00}, and no push or pop occurs that cycle.
REQ-021 In the cycle after a redirect, valid=0; the instruction at the target appears with valid=1 one cycle later.
REQ-022 When count=DEPTH and no pop occurs, fpc holds and no push occurs.
REQ-023 Read and write pointers wrap modulo DEPTH, and count never exceeds DEPTH.
REQ-024 fpc wraps modulo 2^32 on overflow.

Reset
REQ-025 While reset=1 at a clock edge, fpc becomes RESET_PC, the pointers and count become 0, and valid=0; this overrides npc_on and stop.
REQ-026 After reset, ins=0, pc_now=0, count=0 and imem_addr=RESET_PC[IMEM_AW+1:2].
REQ-027 A reset asserted mid-redirect or with a full queue yields the same state as REQ-025.

Configuration
REQ-028 Macro FETCH_QUEUE_BYPASS_EN selects the empty-queue bypass.
REQ-029 With FETCH_QUEUE_BYPASS_EN defined, when count=0, npc_on=0 and reset=0:
- ins=imem_data, pc_now=fpc and valid=1 combinationally.
- If stop=0, the word is consumed without being pushed and fpc advances by 4.
- If stop=1, the word is pushed normally.
REQ-030 Without FETCH_QUEUE_BYPASS_EN, the REQ-019/REQ-021 latencies apply and the outputs never depend combinationally on imem_data.

Verification
REQ-031 Reset, then stop=0 for 6 cycles with a memory holding mem[i]=i+1 -> valid rises 1 cycle after reset; pc_now sequence is 0x3000, 0x3004, 0x3008, ...; ins = 1, 2, 3, ...
REQ-032 stop=1 held for 8 cycles after reset with DEPTH=4 -> count reaches 4 and holds, fpc=0x3010, and pc_now stays at 0x3000.
REQ-033 Full queue, then stop=0 for 1 cycle -> count stays 4, pc_now becomes 0x3004, and 0x3010 is pushed.
REQ-034 npc_on=1 with pc_next=0x3043 while full and stop=1 -> next cycle valid=0 and count=0; the following cycle pc_now=0x3040.
REQ-035 reset=1 together with npc_on=1 -> fpc=0x3000 and count=0.
REQ-036 With FETCH_QUEUE_BYPASS_EN defined, run REQ-031 -> valid=1 in the first cycle after reset with pc_now=0x3000 and count remaining 0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with redirect support.
// Fetches {fpc, imem_data} into a DEPTH-entry circular buffer and presents
// the head entry as ins/pc_now. npc_on flushes the queue and restarts fetch.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward the memory word
// straight to the outputs while the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IMEM_AW  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stop,
    input  logic                     npc_on,
    input  logic [31:0]              pc_next,
    output logic [IMEM_AW-1:0]       imem_addr,
    input  logic [31:0]              imem_data,
    output logic [31:0]              ins,
    output logic [31:0]              pc_now,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];

    logic [31:0]   fpc_q,   fpc_d;
    logic [PW-1:0] rptr_q,  rptr_d;
    logic [PW-1:0] wptr_q,  wptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          q_empty;
    logic          q_full;
    logic          pop;
    logic          push;
    logic          byp_take;

    assign q_empty   = (count_q == '0);
    assign q_full    = (count_q == CW'(DEPTH));
    assign imem_addr = fpc_q[IMEM_AW+1:2];
    assign count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue with a ready consumer hands the fetched word over directly
    assign byp_take = q_empty && !npc_on && !reset && !stop;
`else
    assign byp_take = 1'b0;
`endif

    assign pop  = !q_empty && !stop && !npc_on;
    assign push = !npc_on && (!q_full || pop) && !byp_take;

    // Head presentation: queue head, else (optionally) the bypassed fetch word
    always_comb begin
        ins    = '0;
        pc_now = '0;
        valid  = 1'b0;
        if (!q_empty) begin
            ins    = ins_mem_q[rptr_q];
            pc_now = pc_mem_q[rptr_q];
            valid  = 1'b1;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (!npc_on && !reset) begin
            ins    = imem_data;
            pc_now = fpc_q;
            valid  = 1'b1;
        end
`endif
    end

    // Next-state for fetch PC, pointers and occupancy
    always_comb begin
        fpc_d   = fpc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (npc_on) begin
            // Masking keeps fpc word aligned regardless of the target's low bits
            fpc_d   = pc_next & ~32'h3;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push || byp_take) fpc_d = fpc_q + 32'd4;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push) wptr_d = wptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers; reset overrides redirect and stall
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q   <= RESET_PC;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Queue storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem_q[wptr_q]  <= fpc_q;
            ins_mem_q[wptr_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus a randomized scoreboard run for
// fetch_queue (DEPTH=4, RESET_PC=0x3000, IMEM_AW=10). Honors
// FETCH_QUEUE_BYPASS_EN when defined for both the DUT and the bench.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stop = 1'b0;
    logic        npc_on = 1'b0;
    logic [31:0] pc_next = '0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ins;
    logic [31:0] pc_now;
    logic        valid;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    // Scoreboard: entries {pc, ins} expected at the head, oldest first
    logic [63:0] mq[$];
    logic [31:0] mfpc = RESET_PC;

    always #5 clk = ~clk;

    // Memory holds mem[i] = i + 1
    assign imem_data = {22'd0, imem_addr} + 32'd1;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IMEM_AW(10)) dut (
        .clk(clk), .reset(reset), .stop(stop), .npc_on(npc_on),
        .pc_next(pc_next), .imem_addr(imem_addr), .imem_data(imem_data),
        .ins(ins), .pc_now(pc_now), .valid(valid), .count(count)
    );

    function automatic logic [31:0] memf(input logic [31:0] pc);
        logic [9:0] a;
        a = pc[11:2];
        return {22'd0, a} + 32'd1;
    endfunction

    // Advance the reference model with the inputs present before the edge
    task automatic model_edge();
        bit byp;
        bit popm;
        bit fullm;
        byp = 0;
        if (reset) begin
            mq.delete();
            mfpc = RESET_PC;
        end else if (npc_on) begin
            mq.delete();
            mfpc = {pc_next[31:2], 2'b00};
        end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
            if (mq.size() == 0 && !stop) begin
                byp = 1;
                mfpc = mfpc + 32'd4;
            end
`endif
            if (!byp) begin
                popm  = (mq.size() > 0) && !stop;
                fullm = (mq.size() == DEPTH);
                if (popm) void'(mq.pop_front());
                if (!fullm || popm) begin
                    mq.push_back({mfpc, memf(mfpc)});
                    mfpc = mfpc + 32'd4;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rp;
        logic [9:0]  ea;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eins;
        rp = RESET_PC;
        ea = rp[11:2];
        reset = 1; stop = 0; npc_on = 0;
        tick(); tick();
        reset = 0; stop = 1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        ev = 1; epc = 32'h3000; eins = 32'd1;
`else
        ev = 0; epc = 32'h0; eins = 32'h0;
`endif
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (imem_addr !== ea) begin failures++; $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, ea); end
        checks++; if (valid !== ev) begin failures++; $display("FAIL reset_valid got=%b exp=%b", valid, ev); end
        checks++; if (pc_now !== epc) begin failures++; $display("FAIL reset_pc_now got=%h exp=%h", pc_now, epc); end
        checks++; if (ins !== eins) begin failures++; $display("FAIL reset_ins got=%h exp=%h", ins, eins); end
    endtask

    task automatic test_stream();
        int unsigned off;
        logic [2:0] ec;
`ifdef FETCH_QUEUE_BYPASS_EN
        off = 1; ec = 3'd0;
`else
        off = 0; ec = 3'd1;
`endif
        stop = 0;
        #1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, valid); end
            checks++; if (pc_now !== 32'h3000 + 32'(4 * (i + off))) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, pc_now, 32'h3000 + 32'(4 * (i + off))); end
            checks++; if (ins !== 32'(i + 1 + off)) begin failures++; $display("FAIL stream_ins[%0d] got=%0d exp=%0d", i, ins, i + 1 + off); end
            checks++; if (count !== ec) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", i, count, ec); end
        end
    endtask

    task automatic test_full();
        reset = 1; stop = 1; npc_on = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (pc_now !== 32'h3000) begin failures++; $display("FAIL full_pc got=%h exp=3000", pc_now); end
        checks++; if (ins !== 32'd1) begin failures++; $display("FAIL full_ins got=%0d exp=1", ins); end
        checks++; if (imem_addr !== 10'd4) begin failures++; $display("FAIL full_fpc_addr got=%h exp=004", imem_addr); end
    endtask

    task automatic test_pop_full();
        stop = 0;
        tick();
        stop = 1;
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL popfull_count got=%0d exp=4", count); end
        checks++; if (pc_now !== 32'h3004) begin failures++; $display("FAIL popfull_pc got=%h exp=3004", pc_now); end
        checks++; if (imem_addr !== 10'd5) begin failures++; $display("FAIL popfull_fpc_addr got=%h exp=005", imem_addr); end
        stop = 0;
        tick(); tick(); tick();
        stop = 1;
        #1;
        checks++; if (pc_now !== 32'h3010) begin failures++; $display("FAIL popfull_tail_pc got=%h exp=3010", pc_now); end
        checks++; if (ins !== 32'd5) begin failures++; $display("FAIL popfull_tail_ins got=%0d exp=5", ins); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL popfull_tail_count got=%0d exp=4", count); end
    endtask

    task automatic test_redirect();
        logic        ev;
        logic [31:0] epc;
        npc_on = 1; pc_next = 32'h3043; stop = 1;
        #1;
        tick();
        npc_on = 0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        ev = 1; epc = 32'h3040;
`else
        ev = 0; epc = 32'h0;
`endif
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL redir_count got=%0d exp=0", count); end
        checks++; if (valid !== ev) begin failures++; $display("FAIL redir_valid got=%b exp=%b", valid, ev); end
        checks++; if (pc_now !== epc) begin failures++; $display("FAIL redir_pc got=%h exp=%h", pc_now, epc); end
        tick();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL redir_target_valid got=%b exp=1", valid); end
        checks++; if (pc_now !== 32'h3040) begin failures++; $display("FAIL redir_target_pc got=%h exp=3040", pc_now); end
        checks++; if (ins !== 32'd17) begin failures++; $display("FAIL redir_target_ins got=%0d exp=17", ins); end
    endtask

    task automatic test_reset_redirect();
        reset = 1; npc_on = 1; pc_next = 32'h5000; stop = 1;
        tick();
        reset = 0; npc_on = 0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rstredir_count got=%0d exp=0", count); end
        checks++; if (imem_addr !== 10'd0) begin failures++; $display("FAIL rstredir_fpc_addr got=%h exp=000", imem_addr); end
        tick();
        checks++; if (pc_now !== 32'h3000) begin failures++; $display("FAIL rstredir_pc got=%h exp=3000", pc_now); end
    endtask

    task automatic test_wrap();
        npc_on = 1; pc_next = 32'hFFFF_FFFE; stop = 1;
        tick();
        npc_on = 0;
        tick(); tick();
        checks++; if (pc_now !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", pc_now); end
        checks++; if (ins !== 32'd1024) begin failures++; $display("FAIL wrap_ins got=%0d exp=1024", ins); end
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", count); end
        checks++; if (imem_addr !== 10'd1) begin failures++; $display("FAIL wrap_fpc_addr got=%h exp=001", imem_addr); end
    endtask

    task automatic test_random();
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eins;
        logic [9:0]  ea;
        for (int c = 0; c < 400; c++) begin
            stop    = ($urandom_range(0, 2) == 0);
            npc_on  = ($urandom_range(0, 11) == 0);
            pc_next = $urandom;
            reset   = ($urandom_range(0, 49) == 0);
            #1;
            ev = 0; epc = '0; eins = '0;
            if (mq.size() > 0) begin
                ev = 1; epc = mq[0][63:32]; eins = mq[0][31:0];
            end
`ifdef FETCH_QUEUE_BYPASS_EN
            else if (!reset && !npc_on) begin
                ev = 1; epc = mfpc; eins = memf(mfpc);
            end
`endif
            ea = mfpc[11:2];
            checks++; if (valid !== ev) begin failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", c, valid, ev); end
            checks++; if (pc_now !== epc) begin failures++; $display("FAIL rand_pc[%0d] got=%h exp=%h", c, pc_now, epc); end
            checks++; if (ins !== eins) begin failures++; $display("FAIL rand_ins[%0d] got=%h exp=%h", c, ins, eins); end
            checks++; if (count !== 3'(mq.size())) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", c, count, mq.size()); end
            checks++; if (imem_addr !== ea) begin failures++; $display("FAIL rand_addr[%0d] got=%h exp=%h", c, imem_addr, ea); end
            tick();
        end
        reset = 0; npc_on = 0; stop = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_pop_full();
        test_redirect();
        test_reset_redirect();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
